// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : In-order queue of decode-stage branch predictions. Each entry
//               is checked against the MEM-stage outcome. A mispredict raises
//               a registered flush and a redirect PC, and squashes younger
//               entries. Also drives the predictor training strobe and keeps
//               saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic [31:0]      pred_fallthr_i,
  input  logic             resolve_valid_i,
  input  logic             actual_taken_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             train_valid_o,
  output logic             train_taken_o,
  output logic             q_full_o,
  output logic             q_empty_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] C_STAT_ONE = CNT_W'(1);
  localparam logic [FC_W-1:0]  C_FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  C_FC_ONE = FC_W'(1);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic             taken_q   [DEPTH];
  logic [31:0]      target_q  [DEPTH];
  logic [31:0]      fallthr_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;

  logic             redirect_valid_q, train_valid_q, train_taken_q, err_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic w_run, w_full, w_empty;
  logic w_enq_req, w_deq_req, w_deq, w_enq, w_mispred;
  logic w_overflow, w_empty_resolve;

  assign w_run   = (state_q == S_RUN);
  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);

  // Requests are only honoured while running; in FLUSH both are silently dropped.
  assign w_enq_req = pred_valid_i && w_run;
  assign w_deq_req = resolve_valid_i && w_run;
  assign w_deq     = w_deq_req && !w_empty;
  assign w_mispred = w_deq && (taken_q[rd_ptr_q] != actual_taken_i);
  // A same-cycle enqueue is younger than a mispredicting head, so it is squashed.
  assign w_enq     = w_enq_req && (!w_full || w_deq) && !w_mispred;

  assign w_overflow      = w_enq_req && w_full && !w_deq;
  assign w_empty_resolve = w_deq_req && w_empty;

  // Entry storage; contents need no reset since validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      taken_q[wr_ptr_q]   <= pred_taken_i;
      target_q[wr_ptr_q]  <= pred_target_i;
      fallthr_q[wr_ptr_q] <= pred_fallthr_i;
    end
  end

  // Queue pointers and occupancy; a mispredict empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (w_mispred) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_enq) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_deq) rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      if (w_enq && !w_deq)      count_q <= count_q + C_CNT_ONE;
      else if (!w_enq && w_deq) count_q <= count_q - C_CNT_ONE;
    end
  end

  // Resolution outputs, statistics and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      train_valid_q    <= 1'b0;
      train_taken_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
      err_q            <= 1'b0;
    end else begin
      train_valid_q    <= w_deq;
      train_taken_q    <= w_deq && actual_taken_i;
      redirect_valid_q <= w_mispred;
      if (w_mispred)
        redirect_pc_q <= actual_taken_i ? target_q[rd_ptr_q] : fallthr_q[rd_ptr_q];
      if (w_deq && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + C_STAT_ONE;
      if (w_mispred && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + C_STAT_ONE;
      if (w_overflow || w_empty_resolve)
        err_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM next state: FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (w_mispred) begin
          state_d     = S_FLUSH;
          flush_cnt_d = C_FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_RUN;
        else                   flush_cnt_d = flush_cnt_q - C_FC_ONE;
      end
      default: state_d = S_RUN;
    endcase
  end

  assign flush_o          = (state_q == S_FLUSH);
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign train_valid_o    = train_valid_q;
  assign train_taken_o    = train_taken_q;
  assign q_full_o         = w_full;
  assign q_empty_o        = w_empty;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispred_cnt_o    = mispred_cnt_q;
  assign err_o            = err_q;

endmodule
`default_nettype wire
